// File: rtl/ca_pkg.sv
// Shared types and default sizing for the cellular-automaton status generator
// and its combinational next-generation helper.
package ca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ca_state_t;

  localparam int CA_WIDTH     = 8;
  localparam int CA_MAX_STEPS = 255;
  localparam int CA_CNT_W     = 8;
  localparam int CA_NBR_W     = 3;

endpackage

// File: rtl/ca_next_gen.sv
// Combinational elementary-CA step: next[i] = rule[{left, self, right}].
// Boundary cells read 0 by default; defining CA_WRAP_EN makes the ring periodic.
module ca_next_gen
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH
) (
  input  logic [0:WIDTH-1] status,
  input  logic [7:0]       rule,
  output logic [0:WIDTH-1] next
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic                left;
    logic                right;
    logic [CA_NBR_W-1:0] idx;

    if (i == 0) begin : g_left_edge
`ifdef CA_WRAP_EN
      assign left = status[WIDTH-1];
`else
      assign left = 1'b0;
`endif
    end else begin : g_left_inner
      assign left = status[i-1];
    end

    if (i == WIDTH - 1) begin : g_right_edge
`ifdef CA_WRAP_EN
      assign right = status[0];
`else
      assign right = 1'b0;
`endif
    end else begin : g_right_inner
      assign right = status[i+1];
    end

    assign idx     = {left, status[i], right};
    assign next[i] = rule[idx];
  end

endmodule

// File: rtl/ca_status_generator.sv
// Seeded elementary-CA stepper that streams generations until a fixed point or
// the step limit is reached. Boundary mode is selected by CA_WRAP_EN in ca_next_gen.
module ca_status_generator
  import ca_pkg::*;
#(
  parameter int WIDTH     = CA_WIDTH,
  parameter int MAX_STEPS = CA_MAX_STEPS,
  parameter int CNT_W     = CA_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [0:WIDTH-1] seed,
  input  logic [7:0]       rule,
  input  logic             abort,
  output logic [0:WIDTH-1] status,
  output logic             status_valid,
  input  logic             status_ready,
  output logic [CNT_W-1:0] steps,
  output logic             done,
  output logic             fixed_point,
  output logic             timeout
);

  ca_state_t        state;
  logic [7:0]       rule_q;
  logic [0:WIDTH-1] next;
  logic [CNT_W-1:0] steps_inc;
  logic             accept;
  logic             beat;

  ca_next_gen #(.WIDTH(WIDTH)) u_next_gen (
    .status (status),
    .rule   (rule_q),
    .next   (next)
  );

  assign load_ready   = (state != ST_RUN) && !abort;
  assign accept       = load_valid && load_ready;
  assign status_valid = (state == ST_RUN);
  assign done         = (state == ST_DONE);
  assign beat         = status_valid && status_ready;
  assign steps_inc    = steps + 1'b1;

  // An unchanged next generation is never stored, so fixed_point wins over timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      status      <= '0;
      rule_q      <= '0;
      steps       <= '0;
      fixed_point <= 1'b0;
      timeout     <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      fixed_point <= 1'b0;
      timeout     <= 1'b0;
    end else if (accept) begin
      state       <= ST_RUN;
      status      <= seed;
      rule_q      <= rule;
      steps       <= '0;
      fixed_point <= 1'b0;
      timeout     <= 1'b0;
    end else if (beat) begin
      if (next == status) begin
        state       <= ST_DONE;
        fixed_point <= 1'b1;
      end else begin
        status <= next;
        steps  <= steps_inc;
        if (steps_inc == CNT_W'(MAX_STEPS)) begin
          state   <= ST_DONE;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ca_status_generator.sv
// Bench for ca_status_generator: two instances (default limit and a 4-step limit)
// checked every cycle against a byte-level CA model plus directed literal expectations.
module tb_ca_status_generator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load_valid = 1'b0;
  logic         abort = 1'b0;
  logic         status_ready = 1'b0;
  logic [0:W-1] seed = '0;
  logic [7:0]   rule = '0;

  logic [0:W-1] d_status [2];
  logic [7:0]   d_steps [2];
  logic         d_load_ready [2];
  logic         d_valid [2];
  logic         d_done [2];
  logic         d_fp [2];
  logic         d_to [2];

  int checks = 0;
  int failures = 0;
  int max_steps [2] = '{255, 4};

  // Model state: 0 idle, 1 running, 2 finished.
  int           m_state [2] = '{0, 0};
  logic [0:W-1] m_status [2] = '{8'h00, 8'h00};
  logic [7:0]   m_rule [2] = '{8'h00, 8'h00};
  int           m_steps [2] = '{0, 0};
  bit           m_fp [2] = '{1'b0, 1'b0};
  bit           m_to [2] = '{1'b0, 1'b0};

`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  ca_status_generator u_dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (d_load_ready[0]),
    .seed         (seed),
    .rule         (rule),
    .abort        (abort),
    .status       (d_status[0]),
    .status_valid (d_valid[0]),
    .status_ready (status_ready),
    .steps        (d_steps[0]),
    .done         (d_done[0]),
    .fixed_point  (d_fp[0]),
    .timeout      (d_to[0])
  );

  ca_status_generator #(.MAX_STEPS(4)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (d_load_ready[1]),
    .seed         (seed),
    .rule         (rule),
    .abort        (abort),
    .status       (d_status[1]),
    .status_valid (d_valid[1]),
    .status_ready (status_ready),
    .steps        (d_steps[1]),
    .done         (d_done[1]),
    .fixed_point  (d_fp[1]),
    .timeout      (d_to[1])
  );

  always #5 clk = ~clk;

  function automatic logic [0:W-1] model_next(input logic [0:W-1] s, input logic [7:0] r);
    logic [0:W-1] n;
    int l, c, rt;
    n = '0;
    for (int i = 0; i < W; i++) begin
      c  = int'(s[i]);
      l  = (i == 0)     ? (WRAP ? int'(s[W-1]) : 0) : int'(s[i-1]);
      rt = (i == W - 1) ? (WRAP ? int'(s[0])   : 0) : int'(s[i+1]);
      n[i] = r[l * 4 + c * 2 + rt];
    end
    return n;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d got=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, 0, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_load(input logic [7:0] s, input logic [7:0] r);
    seed = s;
    rule = r;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic apply_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  always @(posedge clk or negedge reset) begin
    logic [0:W-1] nxt;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_state[k] = 0; m_status[k] = '0; m_rule[k] = '0;
        m_steps[k] = 0; m_fp[k] = 1'b0; m_to[k] = 1'b0;
      end else if (abort) begin
        m_state[k] = 0; m_fp[k] = 1'b0; m_to[k] = 1'b0;
      end else if (load_valid && m_state[k] != 1) begin
        m_state[k] = 1; m_status[k] = seed; m_rule[k] = rule;
        m_steps[k] = 0; m_fp[k] = 1'b0; m_to[k] = 1'b0;
      end else if (m_state[k] == 1 && status_ready) begin
        nxt = model_next(m_status[k], m_rule[k]);
        if (nxt == m_status[k]) begin
          m_state[k] = 2;
          m_fp[k] = 1'b1;
        end else begin
          m_status[k] = nxt;
          m_steps[k]++;
          if (m_steps[k] == max_steps[k]) begin
            m_state[k] = 2;
            m_to[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("status",       k, 32'(d_status[k]),     32'(m_status[k]));
      chk("steps",        k, 32'(d_steps[k]),      32'(m_steps[k]));
      chk("status_valid", k, 32'(d_valid[k]),      32'(m_state[k] == 1));
      chk("done",         k, 32'(d_done[k]),       32'(m_state[k] == 2));
      chk("fixed_point",  k, 32'(d_fp[k]),         32'(m_fp[k]));
      chk("timeout",      k, 32'(d_to[k]),         32'(m_to[k]));
      chk("load_ready",   k, 32'(d_load_ready[k]), 32'((m_state[k] != 1) && !abort));
    end
  end

  initial begin
    int n;
    logic [7:0] e;

    #3;
    check_output("rst_valid", 32'(d_valid[0]), 32'h0);
    check_output("rst_load_ready", 32'(d_load_ready[0]), 32'h1);
    check_output("rst_steps", 32'(d_steps[0]), 32'h0);
    check_output("rst_done", 32'(d_done[0]), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("[TB] rule 0x00 collapses to zero then reaches a fixed point");
    status_ready = 1'b1;
    apply_load(8'h5A, 8'h00);
    check_output("r00_seed", 32'(d_status[0]), 32'h5A);
    check_output("r00_valid", 32'(d_valid[0]), 32'h1);
    tick();
    check_output("r00_gen1", 32'(d_status[0]), 32'h00);
    check_output("r00_steps1", 32'(d_steps[0]), 32'h1);
    tick();
    check_output("r00_fp", 32'(d_fp[0]), 32'h1);
    check_output("r00_done", 32'(d_done[0]), 32'h1);
    check_output("r00_steps_final", 32'(d_steps[0]), 32'h1);

    $display("[TB] identity rule terminates on the first beat");
    apply_load(8'h3C, 8'hCC);
    check_output("rcc_valid_once", 32'(d_valid[0]), 32'h1);
    tick();
    check_output("rcc_fp", 32'(d_fp[0]), 32'h1);
    check_output("rcc_steps", 32'(d_steps[0]), 32'h0);
    check_output("rcc_status", 32'(d_status[0]), 32'h3C);
    check_output("rcc_valid_drop", 32'(d_valid[0]), 32'h0);

    $display("[TB] invert rule times out on the 4-step instance");
    apply_load(8'h0F, 8'h33);
    chk("r33_seed", 1, 32'(d_status[1]), 32'h0F);
    for (int k = 1; k <= 4; k++) begin
      tick();
      e = (k % 2 == 1) ? 8'hF0 : 8'h0F;
      chk("r33_gen", 1, 32'(d_status[1]), 32'(e));
      chk("r33_steps", 1, 32'(d_steps[1]), 32'(k));
    end
    chk("r33_timeout", 1, 32'(d_to[1]), 32'h1);
    chk("r33_no_fp", 1, 32'(d_fp[1]), 32'h0);
    chk("r33_done", 1, 32'(d_done[1]), 32'h1);
    apply_abort();

    $display("[TB] copy-left rule shifts a single cell");
    apply_load(8'h80, 8'hF0);
    check_output("rf0_seed", 32'(d_status[0]), 32'h80);
`ifdef CA_WRAP_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = (k == 8) ? 8'h80 : (8'h80 >> k);
      check_output("rf0_rot", 32'(d_status[0]), 32'(e));
    end
    n = 0;
    while (!d_done[0] && n < 300) begin
      tick();
      n++;
    end
    check_output("rf0_done_in_budget", 32'(d_done[0]), 32'h1);
    check_output("rf0_timeout", 32'(d_to[0]), 32'h1);
    check_output("rf0_steps", 32'(d_steps[0]), 32'd255);
    check_output("rf0_final", 32'(d_status[0]), 32'h01);
`else
    for (int k = 1; k <= 8; k++) begin
      tick();
      e = 8'h80 >> k;
      check_output("rf0_shift", 32'(d_status[0]), 32'(e));
      check_output("rf0_shift_steps", 32'(d_steps[0]), 32'(k));
    end
    tick();
    check_output("rf0_fp", 32'(d_fp[0]), 32'h1);
    check_output("rf0_steps", 32'(d_steps[0]), 32'd8);
    check_output("rf0_done", 32'(d_done[0]), 32'h1);
`endif
    apply_abort();

    $display("[TB] backpressure freezes the stream, abort blocks a coincident load");
    apply_load(8'h18, 8'h5A);
    tick();
    check_output("bp_gen1", 32'(d_status[0]), 32'h3C);
    tick();
    check_output("bp_gen2", 32'(d_status[0]), 32'h66);
    status_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output("bp_hold_status", 32'(d_status[0]), 32'h66);
      check_output("bp_hold_steps", 32'(d_steps[0]), 32'h2);
    end
    abort = 1'b1;
    load_valid = 1'b1;
    seed = 8'hFF;
    tick();
    check_output("ab_valid", 32'(d_valid[0]), 32'h0);
    check_output("ab_status_hold", 32'(d_status[0]), 32'h66);
    check_output("ab_steps_hold", 32'(d_steps[0]), 32'h2);
    check_output("ab_done", 32'(d_done[0]), 32'h0);
    abort = 1'b0;
    load_valid = 1'b0;
    tick();
    check_output("ab_idle_ready", 32'(d_load_ready[0]), 32'h1);
    check_output("ab_idle_valid", 32'(d_valid[0]), 32'h0);

    $display("[TB] asynchronous reset mid-run");
    status_ready = 1'b1;
    apply_load(8'h0F, 8'h33);
    tick();
    tick();
    tick();
    check_output("ar_pre_steps", 32'(d_steps[0]), 32'h3);
    #2;
    reset = 1'b0;
    #1;
    check_output("ar_valid", 32'(d_valid[0]), 32'h0);
    check_output("ar_steps", 32'(d_steps[0]), 32'h0);
    check_output("ar_load_ready", 32'(d_load_ready[0]), 32'h1);
    check_output("ar_status", 32'(d_status[0]), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ca_status_generator.md
Name: ca_status_generator

Overview:
- Produces the 8-bit status sequence consumed by the fixed-point checking logic: an elementary cellular-automaton stepper seeded over a load handshake.
- Advances one generation per accepted beat and stops itself on fixed point or step limit.
- Sits upstream of the checker; its status/status_valid stream is the checker's input.
- Reports step count and termination cause.

Parameters:
- WIDTH, 8: number of cells in the status vector.
- MAX_STEPS, 255: generation limit before timeout; range 1..255.
- CNT_W, 8: step counter width; must hold MAX_STEPS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  seed/rule offer.
- load_ready  output  1  generator can accept a load.
- seed  input  [0:WIDTH-1]  initial status; bit 0 is the leftmost cell.
- rule  input  [7:0]  Wolfram rule number, captured on load.
- abort  input  1  return to IDLE.
- status  output  [0:WIDTH-1]  current generation.
- status_valid  output  1  status holds a live generation.
- status_ready  input  1  consumer accepts the current generation.
- steps  output  CNT_W  generations advanced since load.
- done  output  1  run terminated.
- fixed_point  output  1  terminated because next generation equals current.
- timeout  output  1  terminated at MAX_STEPS.

Behaviour:
- Reset (reset=0, async): state=IDLE; status=0, steps=0, captured rule=0; status_valid, done, fixed_point and timeout all 0; load_ready=1.
- States: IDLE, RUN, DONE.
  - IDLE/DONE to RUN on load accept.
  - RUN to DONE on termination.
  - Any state to IDLE on abort.
- load_ready = (state is IDLE or DONE) and not abort.
- Accept = load_valid and load_ready, sampled at a rising edge.
- On accept, next cycle:
  - status=seed, rule captured, steps=0.
  - status_valid=1; done, fixed_point and timeout cleared.
  - State RUN.
- Next-generation function:
  - For cell i: idx = {cell i-1, cell i, cell i+1}; next[i] = rule[idx].
  - Out-of-range neighbours read 0 (null boundary).
- In RUN, a beat fires when status_valid and status_ready:
  - If next == status: state DONE, fixed_point=1, status and steps unchanged.
  - Else: status<=next and steps<=steps+1.
  - If steps+1 == MAX_STEPS: state DONE and timeout=1 in the same cycle; the final generation is still presented.
  - If both conditions would hold, fixed_point has priority. This is unreachable: an equal next is never stored.
- Without a beat: status, steps and state hold. status is stable while status_valid=1 and status_ready=0.
- status_valid is 1 only in RUN and drops the cycle after the terminating beat.
- In DONE, status, steps and flags hold until the next accept or abort. done=1 exactly in DONE.
- abort has priority over everything:
  - Next cycle state=IDLE, status_valid=0, flags cleared.
  - status and steps hold their last values.
  - A load_valid coincident with abort is not accepted.
- Reset mid-run drops the run immediately; there is no partial completion.
- Latency:
  - Load accept to first status_valid: 1 cycle.
  - Each accepted beat to next generation visible: 1 cycle.
  - No combinational path from status_ready to status.

Optional Feature:
- Macro: CA_WRAP_EN.
- Defined: periodic boundary. Cell 0's left neighbour is cell WIDTH-1, and cell WIDTH-1's right neighbour is cell 0.
- Undefined: null boundary (0) as specified above.
- Handshake and termination rules are identical in both builds.

Decomposition:
- Shared package ca_pkg holds:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH and MAX_STEPS constants.
  - Neighbourhood index width constant (3).
- One sub-module: ca_next_gen, purely combinational.
  - Inputs status and rule; output next.
  - Contains the CA_WRAP_EN boundary selection.
  - Reusable by the checker's bench as a reference model.

Test Plan:
- Rule 0x00, seed 0x5A, status_ready=1: 0x5A then 0x00, steps=1; next beat gives fixed_point=1, done=1, steps=1.
- Rule 0xCC (identity), seed 0x3C: first beat gives fixed_point=1, steps=0, status=0x3C; status_valid high for exactly 1 cycle.
- Rule 0x33 (invert), seed 0x0F, MAX_STEPS=4: sequence 0x0F, 0xF0, 0x0F, 0xF0, 0x0F; timeout=1, steps=4, fixed_point=0.
- Rule 0xF0 (copy left), seed 0x80:
  - Null boundary: 0x80, 0x40 … 0x01, 0x00, then fixed at steps=8.
  - With CA_WRAP_EN: rotation continues; timeout at MAX_STEPS=255.
- Backpressure: status_ready held 0 for 5 cycles mid-run means status and steps stay frozen. Then abort together with load_valid=1 gives IDLE next cycle with the load not accepted.
- Async reset asserted mid-run at steps=3 gives status_valid=0, steps=0 and load_ready=1 without a clock edge.
